mux_rr: RTL and testbench



---
 rtl/mux_rr.sv | 145 ++++++++++++++
 tb/tb_mux_rr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr.sv
// N-channel W-bit registered multiplexer with valid/ready on every port; fixed-select or round-robin grant.
// Optional packet lock when MUX_RR_LOCK_EN is defined (holds grant on one channel until a_last).
module mux_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] a,
  input  logic [N-1:0]   a_valid,
  input  logic [N-1:0]   a_last,
  output logic [N-1:0]   a_ready,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  y_sel,
  output logic           y_valid,
  input  logic           y_ready
);

  // Handshake: a beat moves on channel i when a_valid[i] && a_ready[i]; the output
  // beat is consumed when y_valid && y_ready. a_ready never depends on a_valid[i] alone.

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] y_sel_q, y_sel_d;
  logic          y_valid_q, y_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          ld;
  logic [SW-1:0] rr_gnt, fx_gnt, gnt;
  logic          rr_ok, fx_ok, gnt_ok;
  logic          xfer;
  logic [W-1:0]  gnt_data;

  assign ld = !y_valid_q || y_ready;

  // Round-robin: walk downwards so the nearest valid channel after ptr wins.
  always_comb begin
    rr_gnt = '0;
    rr_ok  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (a_valid[(int'(ptr_q) + k) % N]) begin
        rr_gnt = SW'((int'(ptr_q) + k) % N);
        rr_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    fx_gnt = sel;
    fx_ok  = 1'b0;
    if (int'(sel) < N) fx_ok = a_valid[sel];
  end

`ifdef MUX_RR_LOCK_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    gnt    = mode ? rr_gnt : fx_gnt;
    gnt_ok = mode ? rr_ok  : fx_ok;
    if (lock_q) begin
      gnt    = lock_ch_q;
      gnt_ok = a_valid[lock_ch_q];
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = !a_last[gnt];
      lock_ch_d = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  logic unused_a_last;
  assign unused_a_last = ^a_last;

  always_comb begin
    gnt    = mode ? rr_gnt : fx_gnt;
    gnt_ok = mode ? rr_ok  : fx_ok;
  end
`endif

  // Ready is withheld during reset even though the output register reads empty.
  assign xfer = ld && gnt_ok && !rst;

  always_comb begin
    a_ready = '0;
    if (xfer) a_ready[gnt] = 1'b1;
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == gnt) gnt_data = a[i*W +: W];
    end
  end

  always_comb begin
    y_d       = y_q;
    y_sel_d   = y_sel_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      y_d       = gnt_data;
      y_sel_d   = gnt;
      y_valid_d = 1'b1;
      ptr_d     = gnt;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      y_sel_q   <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= SW'(N - 1);
    end else begin
      y_q       <= y_d;
      y_sel_q   <= y_sel_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_sel   = y_sel_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_rr.sv
// Bench for mux_rr (N=4, W=8): vector table, directed corner sequences and random traffic
// compared against a grant-by-distance reference model.
module tb_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] a;
  logic [N-1:0]   a_valid;
  logic [N-1:0]   a_last;
  logic [N-1:0]   a_ready;
  logic [W-1:0]   y;
  logic [1:0]     y_sel;
  logic           y_valid;
  logic           y_ready;

  mux_rr #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .a(a),
    .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .y(y), .y_sel(y_sel), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit         m_yv;
  logic [7:0] m_y;
  int         m_ysel;
  int         m_last;
  int         m_lock;

  typedef struct {
    bit         mode;
    logic [1:0] sel;
    logic [3:0] av;
    bit         yr;
    logic [3:0] er;
    bit         eyv;
    logic [1:0] esel;
    logic [7:0] ey;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] chan(input int c);
    return a[c*W +: W];
  endfunction

  function automatic void model_reset();
    m_yv = 0; m_y = '0; m_ysel = 0; m_last = N - 1; m_lock = -1;
  endfunction

  // Round-robin winner = valid channel at the smallest rotational distance past the last grant.
  function automatic void model_grant(output int g, output bit ok);
    int best;
    g = 0; ok = 0; best = N;
    if (m_lock >= 0) begin
      g = m_lock; ok = a_valid[m_lock];
    end else if (!mode) begin
      g = int'(sel); ok = (g < N) && a_valid[g];
    end else begin
      for (int c = 0; c < N; c++) begin
        int d;
        d = (c - m_last - 1 + 2*N) % N;
        if (a_valid[c] && d < best) begin best = d; g = c; ok = 1; end
      end
    end
  endfunction

  function automatic logic [3:0] model_ready();
    int g; bit ok;
    model_grant(g, ok);
    if ((!m_yv || y_ready) && ok) return 4'(1 << g);
    return 4'b0;
  endfunction

  function automatic void model_update();
    int g; bit ok;
    model_grant(g, ok);
    if ((!m_yv || y_ready) && ok) begin
      m_yv = 1; m_y = chan(g); m_ysel = g; m_last = g;
`ifdef MUX_RR_LOCK_EN
      m_lock = a_last[g] ? -1 : g;
`endif
    end else if (y_ready) begin
      m_yv = 0;
    end
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    #1;
    check("a_ready", 32'(a_ready), 32'(model_ready()));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("y_valid", 32'(y_valid), 32'(m_yv));
    check("y", 32'(y), 32'(m_y));
    check("y_sel", 32'(y_sel), 32'(m_ysel));
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_sel", 32'(y_sel), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    int sq[8];
    int beats;
    int g; bit ok;
    logic [1:0] lock_exp[4];

    mode = 0; sel = 0; a_valid = '0; a_last = '1; y_ready = 1;
    a = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();

    // mode sel av yr | a_ready y_valid y_sel y   (each applied fresh out of reset)
    tbl[0] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[1] = '{1'b0, 2'd1, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[2] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h3C};
    tbl[3] = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hC3};
    tbl[4] = '{1'b1, 2'd2, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h5A};
    tbl[5] = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 8'hC3};
    tbl[6] = '{1'b1, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[7] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h3C};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mode = tbl[i].mode; sel = tbl[i].sel; a_valid = tbl[i].av; y_ready = tbl[i].yr;
      #1;
      check("tbl_a_ready", 32'(a_ready), 32'(tbl[i].er));
      @(posedge clk);
      @(negedge clk);
      check("tbl_y_valid", 32'(y_valid), 32'(tbl[i].eyv));
      check("tbl_y_sel", 32'(y_sel), 32'(tbl[i].esel));
      check("tbl_y", 32'(y), 32'(tbl[i].ey));
    end

    // Round-robin fairness
    do_reset();
    mode = 1; a_valid = 4'b1111; y_ready = 1;
    sq = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_seq", 32'(y_sel), 32'(sq[i]));
    end

    // Backpressure hold then release
    do_reset();
    mode = 1; a_valid = 4'b0011; y_ready = 1;
    step();
    y_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", 32'(a_ready), 32'd0);
      check("bp_hold_sel", 32'(y_sel), 32'd0);
      check("bp_hold_y", 32'(y), 32'h3C);
      check("bp_hold_v", 32'(y_valid), 32'd1);
    end
    y_ready = 1;
    step();
    check("bp_release", 32'(y_sel), 32'd1);

    // Wrap: 0 -> 3 -> 0
    do_reset();
    mode = 1; a_valid = 4'b1001; y_ready = 1;
    step(); check("wrap0", 32'(y_sel), 32'd0);
    step(); check("wrap3", 32'(y_sel), 32'd3);
    step(); check("wrap0b", 32'(y_sel), 32'd0);

    // Reset while holding a beat, then lowest valid wins
    mode = 0; sel = 2; a_valid = 4'b0100; y_ready = 0;
    step();
    do_reset();
    mode = 1; a_valid = 4'b0110; y_ready = 1;
    step();
    check("post_rst_first", 32'(y_sel), 32'd1);

    // Packet on channel 1 against continuously valid channel 2
`ifdef MUX_RR_LOCK_EN
    lock_exp = '{2'd1, 2'd1, 2'd1, 2'd2};
`else
    lock_exp = '{2'd1, 2'd2, 2'd1, 2'd2};
`endif
    do_reset();
    mode = 1; y_ready = 1; beats = 3;
    for (int i = 0; i < 4; i++) begin
      a_valid = {1'b0, 1'b1, beats > 0, 1'b0};
      a_last  = {1'b1, 1'b1, beats == 1, 1'b1};
      model_grant(g, ok);
      step();
      if (ok && g == 1) beats--;
      check("lock_seq", 32'(y_sel), 32'(lock_exp[i]));
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mode    = 1'($urandom_range(0, 1));
      sel     = 2'($urandom_range(0, 3));
      a_valid = 4'($urandom_range(0, 15));
      a_last  = 4'($urandom_range(0, 15));
      y_ready = ($urandom_range(0, 3) != 0);
      a       = 32'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
